// File: rtl/peak_track.sv
// Per-channel running max/min/first-argmax over a sof..eof frame, latched into held registers at eof.
// Samples accepted every cycle (no backpressure); held read port has 1-cycle latency, res_valid pulses the cycle after eof.
module peak_track #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 10,
  parameter int DECAY    = 1,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             sof,
  input  logic             eof,
  input  logic             w_ena,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             hold_en,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [WIDTH-1:0] rd_max,
  output logic [WIDTH-1:0] rd_min,
  output logic [IDX_W-1:0] rd_argmax,
  output logic             rd_empty,
  output logic             res_valid
);

  typedef struct packed {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] arg;
    logic             seen;
  } run_t;

  typedef struct packed {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic [IDX_W-1:0] arg;
    logic             empty;
  } held_t;

  localparam run_t  RUN_RST  = '{mx: '0, mn: '1, idx: '0, arg: '0, seen: 1'b0};
  localparam held_t HELD_RST = '{mx: '0, mn: '0, arg: '0, empty: 1'b1};
  localparam logic [WIDTH-1:0] DEC = WIDTH'(DECAY);

  run_t             run_q    [CHANNELS];
  run_t             run_upd  [CHANNELS];
  run_t             run_nxt  [CHANNELS];
  held_t            held_q   [CHANNELS];
  held_t            held_nxt [CHANNELS];
  logic [WIDTH-1:0] decayed  [CHANNELS];

  // A lone sof starts the new frame before the concurrent sample is applied;
  // with eof present the sample belongs to the frame being latched instead.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      run_upd[c] = (sof && !eof) ? RUN_RST : run_q[c];
      if (w_ena && int'(ch_sel) == c) begin
        if (din > run_upd[c].mx) begin
          run_upd[c].mx  = din;
          run_upd[c].arg = run_upd[c].idx;
        end
        if (din < run_upd[c].mn) run_upd[c].mn = din;
        if (run_upd[c].idx != '1) run_upd[c].idx = run_upd[c].idx + IDX_W'(1);
        run_upd[c].seen = 1'b1;
      end
      run_nxt[c] = (sof && eof) ? RUN_RST : run_upd[c];

      decayed[c]         = (held_q[c].mx > DEC) ? held_q[c].mx - DEC : '0;
      held_nxt[c].mx     = (hold_en && decayed[c] > run_upd[c].mx) ? decayed[c] : run_upd[c].mx;
      held_nxt[c].mn     = run_upd[c].mn;
      held_nxt[c].arg    = run_upd[c].arg;
      held_nxt[c].empty  = !run_upd[c].seen;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        run_q[c]  <= RUN_RST;
        held_q[c] <= HELD_RST;
      end
      res_valid <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        run_q[c] <= run_nxt[c];
        if (eof) held_q[c] <= held_nxt[c];
      end
      res_valid <= eof;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rd_max    <= '0;
      rd_min    <= '0;
      rd_argmax <= '0;
      rd_empty  <= 1'b1;
    end else if (int'(rd_ch) < CHANNELS) begin
      rd_max    <= held_q[rd_ch].mx;
      rd_min    <= held_q[rd_ch].mn;
      rd_argmax <= held_q[rd_ch].arg;
      rd_empty  <= held_q[rd_ch].empty;
    end else begin
      rd_max    <= '0;
      rd_min    <= '0;
      rd_argmax <= '0;
      rd_empty  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_peak_track.sv
// Bench for peak_track: 3 channels (so rd_ch/ch_sel can go out of range) and a 4-bit index to reach saturation.
module tb_peak_track;
  localparam int WIDTH = 8, CHANNELS = 3, IDX_W = 4, DECAY = 1, CH_W = 2;

  logic             clock = 1'b0;
  logic             aclr, sof, eof, w_ena, hold_en;
  logic [CH_W-1:0]  ch_sel, rd_ch;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] rd_max, rd_min;
  logic [IDX_W-1:0] rd_argmax;
  logic             rd_empty, res_valid;
  logic             rd_req  = 1'b0;
  logic             rd_pend = 1'b0;

  peak_track #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .IDX_W(IDX_W), .DECAY(DECAY)) dut (
    .clock(clock), .aclr(aclr), .sof(sof), .eof(eof), .w_ena(w_ena), .ch_sel(ch_sel),
    .din(din), .hold_en(hold_en), .rd_ch(rd_ch), .rd_max(rd_max), .rd_min(rd_min),
    .rd_argmax(rd_argmax), .rd_empty(rd_empty), .res_valid(res_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    mx, mn, arg, emp;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic samp(input int ch, input int d);
    w_ena = 1'b1; ch_sel = ch[CH_W-1:0]; din = d[WIDTH-1:0];
    tick;
    w_ena = 1'b0;
  endtask

  task automatic start_frame;
    sof = 1'b1;
    tick;
    sof = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    eof = 1'b1;
    tick;
    eof = 1'b0;
    chk({tag, ".res_valid"}, res_valid, 1);
    tick;
    chk({tag, ".res_valid_clr"}, res_valid, 0);
  endtask

  // Expected read result is queued when the address is driven, compared when it emerges.
  task automatic rd(input int ch, input int mx, input int mn, input int arg, input int emp, input string tag);
    exp_t e;
    e.tag = tag; e.mx = mx; e.mn = mn; e.arg = arg; e.emp = emp;
    exp_q.push_back(e);
    rd_ch  = ch[CH_W-1:0];
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
  endtask

  always @(posedge clock) rd_pend <= rd_req;

  always @(negedge clock) begin : sb_mon
    exp_t e;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({e.tag, ".max"},    rd_max,    e.mx);
        chk({e.tag, ".min"},    rd_min,    e.mn);
        chk({e.tag, ".argmax"}, rd_argmax, e.arg);
        chk({e.tag, ".empty"},  rd_empty,  e.emp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    aclr = 1'b1; sof = 1'b0; eof = 1'b0; w_ena = 1'b0; ch_sel = '0; din = '0;
    hold_en = 1'b0; rd_ch = '0;
    #2;
    chk("rst.max", rd_max, 0);
    chk("rst.min", rd_min, 0);
    chk("rst.argmax", rd_argmax, 0);
    chk("rst.empty", rd_empty, 1);
    chk("rst.res_valid", res_valid, 0);
    tick; tick;
    aclr = 1'b0;
    tick;

    // Basic frame, plus an out-of-range sample that must be dropped
    start_frame;
    samp(0, 5); samp(0, 9); samp(0, 3); samp(0, 9); samp(3, 250);
    end_frame("basic");
    rd(0, 9, 3, 1, 0, "basic_ch0");
    rd(1, 0, 255, 0, 1, "basic_ch1");
    rd(2, 0, 255, 0, 1, "basic_ch2");
    rd(3, 0, 0, 0, 1, "oor_read");

    // Sample with eof+sof: included in latched frame, not carried forward
    start_frame;
    samp(2, 100);
    w_ena = 1'b1; ch_sel = 2; din = 200; eof = 1'b1; sof = 1'b1;
    tick;
    w_ena = 1'b0; eof = 1'b0; sof = 1'b0;
    chk("se.res_valid", res_valid, 1);
    rd(2, 200, 100, 1, 0, "se_ch2");
    samp(2, 50);
    eof = 1'b1;
    rd(2, 200, 100, 1, 0, "rd_during_eof");
    eof = 1'b0;
    rd(2, 50, 50, 0, 0, "rd_after_eof");

    // Sample with a lone sof is the first of the new frame
    samp(1, 200);
    sof = 1'b1; w_ena = 1'b1; ch_sel = 1; din = 64;
    tick;
    sof = 1'b0; w_ena = 1'b0;
    samp(1, 128);
    end_frame("sof_w");
    rd(1, 128, 64, 1, 0, "sof_w_ch1");

    // Peak hold with decay
    hold_en = 1'b1;
    start_frame;
    samp(0, 100);
    end_frame("hold1");
    rd(0, 100, 100, 0, 0, "hold1");
    for (int k = 2; k <= 4; k++) begin
      start_frame;
      samp(0, 5); samp(0, 10);
      end_frame("holdn");
      rd(0, 101 - k, 5, 1, 0, $sformatf("hold%0d", k));
    end
    hold_en = 1'b0;
    start_frame;
    samp(0, 5); samp(0, 10);
    end_frame("hold_off");
    rd(0, 10, 5, 1, 0, "hold_off");

    // Index saturation at 2^IDX_W-1
    start_frame;
    for (int k = 0; k < 20; k++) samp(2, 10 * (k + 1));
    end_frame("idx_sat");
    rd(2, 200, 10, 15, 0, "idx_sat");

    // Reset mid-frame discards the frame
    start_frame;
    samp(0, 1); samp(0, 2); samp(0, 3);
    aclr = 1'b1;
    #1;
    chk("mid_rst.max", rd_max, 0);
    chk("mid_rst.min", rd_min, 0);
    chk("mid_rst.argmax", rd_argmax, 0);
    chk("mid_rst.empty", rd_empty, 1);
    chk("mid_rst.res_valid", res_valid, 0);
    tick;
    aclr = 1'b0;
    tick;
    chk("mid_rst.no_res_valid", res_valid, 0);
    end_frame("post_rst");
    rd(0, 0, 255, 0, 1, "post_rst_ch0");
    rd(1, 0, 255, 0, 1, "post_rst_ch1");
    rd(2, 0, 255, 0, 1, "post_rst_ch2");

    tick;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
